// File: rtl/pin_vector_driver.sv
// Drives host test vectors onto a wrapped DUT's pins, samples the DUT
// outputs through a synchronizer and returns a compare result record.
module pin_vector_driver #(
    parameter int NUM_PINS      = 12,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                vec_valid,
    output logic                vec_ready,
    input  logic [NUM_PINS-1:0] vec_drive,
    input  logic [NUM_PINS-1:0] vec_dir,
    input  logic [NUM_PINS-1:0] vec_expect,
    input  logic [NUM_PINS-1:0] vec_mask,
    input  logic [NUM_PINS-1:0] dut_dir,
    output logic [NUM_PINS-1:0] pin_out,
    output logic [NUM_PINS-1:0] pin_oe,
    input  logic [NUM_PINS-1:0] pin_in,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                res_pass,
    output logic [NUM_PINS-1:0] res_mismatch,
    output logic [NUM_PINS-1:0] res_sample,
    output logic                res_contention,
    output logic [15:0]         vec_count,
    output logic [15:0]         err_count
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DRIVE  = 2'd1;
    localparam logic [1:0] REPORT = 2'd2;

    localparam logic [8:0] SETTLE_LOAD = 9'(SETTLE_CYCLES + 2);

    logic [1:0]          state;
    logic [8:0]          settle;
    logic [NUM_PINS-1:0] held_drive;
    logic [NUM_PINS-1:0] held_dir;
    logic [NUM_PINS-1:0] held_expect;
    logic [NUM_PINS-1:0] held_mask;
    logic [NUM_PINS-1:0] contend;
    logic [NUM_PINS-1:0] sync1;
    logic [NUM_PINS-1:0] sync2;
    logic [NUM_PINS-1:0] miss;
    logic [15:0]         vec_total;
    logic [15:0]         err_total;

    assign vec_ready = (state == IDLE);
    assign res_valid = (state == REPORT);
    assign vec_count = vec_total;
    assign err_count = err_total;
    assign miss      = (sync2 ^ held_expect) & held_mask;

    // Pad values are asynchronous; two flops before anything looks at them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pin_in;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            settle         <= '0;
            held_drive     <= '0;
            held_dir       <= '0;
            held_expect    <= '0;
            held_mask      <= '0;
            contend        <= '0;
            pin_out        <= '0;
            pin_oe         <= '0;
            res_pass       <= 1'b0;
            res_mismatch   <= '0;
            res_sample     <= '0;
            res_contention <= 1'b0;
            vec_total      <= '0;
            err_total      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (vec_valid) begin
                        held_drive  <= vec_drive;
                        held_dir    <= vec_dir;
                        held_expect <= vec_expect;
                        held_mask   <= vec_mask;
                        contend     <= vec_dir & ~dut_dir;
                        settle      <= SETTLE_LOAD;
                        state       <= DRIVE;
                    end
                end
                DRIVE: begin
                    pin_out <= held_drive & held_dir;
                    pin_oe  <= held_dir & ~contend;
                    settle  <= settle - 9'd1;
                    // Last settle count: sync2 now holds the settled pad value.
                    if (settle == 9'd0) begin
                        res_sample     <= sync2;
                        res_mismatch   <= miss;
                        res_contention <= |contend;
                        res_pass       <= ~|miss & ~|contend;
                        state          <= REPORT;
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        vec_total <= vec_total + 16'd1;
                        if (!res_pass && err_total != 16'hFFFF) begin
                            err_total <= err_total + 16'd1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
